// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions used by the display encoder and the scan decoder.
// Segment bytes are active-low, bit7..bit0 = a,b,c,d,e,f,g,dp, with dp off.
package ssd_pkg;

  localparam logic [7:0] SS_0     = 8'h03;
  localparam logic [7:0] SS_1     = 8'h9F;
  localparam logic [7:0] SS_2     = 8'h25;
  localparam logic [7:0] SS_3     = 8'h0D;
  localparam logic [7:0] SS_4     = 8'h99;
  localparam logic [7:0] SS_5     = 8'h49;
  localparam logic [7:0] SS_6     = 8'h41;
  localparam logic [7:0] SS_7     = 8'h1F;
  localparam logic [7:0] SS_8     = 8'h01;
  localparam logic [7:0] SS_9     = 8'h09;
  localparam logic [7:0] SS_A     = 8'h11;
  localparam logic [7:0] SS_B     = 8'hC1;
  localparam logic [7:0] SS_C     = 8'h63;
  localparam logic [7:0] SS_D     = 8'h85;
  localparam logic [7:0] SS_E     = 8'h61;
  localparam logic [7:0] SS_F     = 8'h71;
  localparam logic [7:0] SS_BLANK = 8'hFF;

  localparam logic [3:0] DIG0 = 4'b1110;
  localparam logic [3:0] DIG1 = 4'b1101;
  localparam logic [3:0] DIG2 = 4'b1011;
  localparam logic [3:0] DIG3 = 4'b0111;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       err;
  } digit_t;

  // True when exactly one active-low digit enable is asserted.
  function automatic logic is_one_cold(input logic [3:0] ctl);
    return $onehot(~ctl);
  endfunction

  function automatic digit_idx_t cold_index(input logic [3:0] ctl);
    digit_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!ctl[i]) idx = digit_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ssd_seg2hex.sv
// Maps an active-low a..g segment pattern back to its hex nibble.
// Patterns outside the 16-glyph table return nibble 0 with invalid set.
module ssd_seg2hex
  import ssd_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       invalid
);

  // NOTE: both outputs get a default first, so no path through the case can infer a latch.
  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (pattern)
      SS_0[7:1]: nibble = 4'h0;
      SS_1[7:1]: nibble = 4'h1;
      SS_2[7:1]: nibble = 4'h2;
      SS_3[7:1]: nibble = 4'h3;
      SS_4[7:1]: nibble = 4'h4;
      SS_5[7:1]: nibble = 4'h5;
      SS_6[7:1]: nibble = 4'h6;
      SS_7[7:1]: nibble = 4'h7;
      SS_8[7:1]: nibble = 4'h8;
      SS_9[7:1]: nibble = 4'h9;
      SS_A[7:1]: nibble = 4'hA;
      SS_B[7:1]: nibble = 4'hB;
      SS_C[7:1]: nibble = 4'hC;
      SS_D[7:1]: nibble = 4'hD;
      SS_E[7:1]: nibble = 4'hE;
      SS_F[7:1]: nibble = 4'hF;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Loopback monitor for the multiplexed 4-digit display bus: synchronizes, debounces,
// decodes each digit and publishes a complete 16-bit frame once all four were seen.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  D_ssd,
  input  logic [3:0]  ssd_ctl,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic [3:0]  frame_err,
  output logic        busy
);

  localparam logic [7:0] STABLE  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic [11:0] sync_q [SYNC_STAGES];
  logic [7:0]  s_seg;
  logic [3:0]  s_ctl;
  logic [11:0] prev_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_now;
  logic        changed;
  logic        capture;
  digit_idx_t  cap_idx;
  logic [3:0]  dec_nib;
  logic        dec_invalid;
  digit_t [3:0] stage_q;
  logic [3:0]  seen_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {D_ssd, ssd_ctl};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {s_seg, s_ctl} = sync_q[SYNC_STAGES-1];

  ssd_seg2hex u_seg2hex (
    .pattern (s_seg[7:1]),
    .nibble  (dec_nib),
    .invalid (dec_invalid)
  );

  // cnt_now is the length of the current dwell including this cycle.
  always_comb begin
    changed = ({s_seg, s_ctl} != prev_q);
    if (changed)               cnt_now = 8'd1;
    else if (cnt_q == CNT_MAX) cnt_now = CNT_MAX;
    else                       cnt_now = cnt_q + 8'd1;
    // The second term stops a counter parked at 255 from recapturing every cycle.
    capture = is_one_cold(s_ctl) && (cnt_now == STABLE) && (changed || (cnt_q != STABLE));
    cap_idx = cold_index(s_ctl);
  end

  // NOTE: the staging array is four small flop registers rather than a RAM, so reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      stage_q     <= '0;
      seen_q      <= '0;
      value       <= '0;
      dp          <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      prev_q      <= {s_seg, s_ctl};
      cnt_q       <= cnt_now;
      frame_valid <= (seen_q == 4'hF);
      if (seen_q == 4'hF) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          value[4*k +: 4] <= stage_q[k].nib;
          dp[k]           <= stage_q[k].dp;
          frame_err[k]    <= stage_q[k].err;
        end
      end
      if (capture) stage_q[cap_idx] <= '{nib: dec_nib, dp: ~s_seg[0], err: dec_invalid};
      // A capture landing on the completion cycle starts the next frame.
      seen_q <= ((seen_q == 4'hF) ? 4'h0 : seen_q) | (capture ? (4'b0001 << cap_idx) : 4'h0);
    end
  end

  assign busy = |seen_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed and randomized scan sequences checked against a dwell-level model of the decoder.
module tb_ssd_scan_decoder;
  import ssd_pkg::*;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + STABLE + 1;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  d_ssd;
  logic [3:0]  ssd_ctl;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        frame_valid;
  logic [3:0]  frame_err;
  logic        busy;

  ssd_scan_decoder #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .D_ssd       (d_ssd),
    .ssd_ctl     (ssd_ctl),
    .value       (value),
    .dp          (dp),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Glyph table written straight from the decode rules, independent of the package.
  logic [6:0] ref_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int tests = 0;
  int fails = 0;

  // Reference model state: current dwell and the partially collected frame.
  logic [11:0] last = 'x;
  int          run = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_err = '0;
  logic [3:0]  m_seen = '0;
  frame_t      exp_q[$];
  int          exp_rd = 0;

  // Monitor observations.
  int          cyc = 0;
  frame_t      obs_q[$];
  int          obs_cyc[$];
  int          busy_cnt = 0;
  int          bad_change = 0;
  logic [23:0] prev_out = 'x;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      obs_q.push_back('{value, dp, frame_err});
      obs_cyc.push_back(cyc);
    end
    if (rst_n && busy) busy_cnt++;
    if (rst_n && !frame_valid && ({value, dp, frame_err} !== prev_out)) bad_change++;
    prev_out = {value, dp, frame_err};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed t=%0t required earlier end", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds a bus pattern for n clocks; the model captures a digit when its merged
  // dwell first reaches STABLE cycles with exactly one digit enabled.
  task automatic drive(input logic [7:0] seg, input logic [3:0] ctl, input int n);
    int          k;
    logic [3:0]  nib;
    logic        bad;
    d_ssd   = seg;
    ssd_ctl = ctl;
    if ({seg, ctl} !== last) run = 0;
    if (run < STABLE && run + n >= STABLE && $countones(~ctl) == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!ctl[i]) k = i;
      bad = 1'b1;
      nib = 4'h0;
      for (int i = 0; i < 16; i++) begin
        if (seg[7:1] == ref_tab[i]) begin
          nib = 4'(i);
          bad = 1'b0;
        end
      end
      m_val[k*4 +: 4] = nib;
      m_dp[k]         = ~seg[0];
      m_err[k]        = bad;
      m_seen[k]       = 1'b1;
      if (m_seen == 4'hF) begin
        exp_q.push_back('{m_val, m_dp, m_err});
        m_seen = 4'h0;
      end
    end
    run  = run + n;
    last = {seg, ctl};
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    d_ssd   = SS_BLANK;
    ssd_ctl = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_value"}, 32'(value), 32'h0);
    check({tag, "_dp"}, 32'(dp), 32'h0);
    check({tag, "_err"}, 32'(frame_err), 32'h0);
    check({tag, "_fv"}, 32'(frame_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    m_val  = '0;
    m_dp   = '0;
    m_err  = '0;
    m_seen = '0;
    last   = 'x;
    run    = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_rd < exp_q.size()) begin
      if (exp_rd < obs_q.size()) check({tag, "_frame"}, 32'(obs_q[exp_rd]), 32'(exp_q[exp_rd]));
      exp_rd++;
    end
  endtask

  initial begin
    logic [7:0] seg_r;
    logic [3:0] ctl_r;
    int         c0, n0, n1, b0;

    d_ssd   = SS_BLANK;
    ssd_ctl = 4'hF;
    @(negedge clk);
    do_reset("init");

    // Plain scan of 4,3,2,1.
    drive(SS_4, DIG0, 8);
    drive(SS_3, DIG1, 8);
    drive(SS_2, DIG2, 8);
    drive(SS_1, DIG3, 8);
    drive(SS_BLANK, 4'hF, 20);
    check_frames("basic");
    check("basic_value", 32'(value), 32'h1234);
    check("basic_dp", 32'(dp), 32'h0);
    check("basic_err", 32'(frame_err), 32'h0);

    // Every dwell one cycle short of the threshold.
    b0 = busy_cnt;
    n0 = obs_q.size();
    repeat (2) begin
      drive(SS_8, DIG0, STABLE - 1);
      drive(SS_8, DIG1, STABLE - 1);
      drive(SS_8, DIG2, STABLE - 1);
      drive(SS_8, DIG3, STABLE - 1);
    end
    drive(SS_BLANK, 4'hF, 20);
    check("short_busy", 32'(busy_cnt - b0), 32'h0);
    check("short_frames", 32'(obs_q.size() - n0), 32'h0);
    check_frames("short");

    // Glitch mid-dwell on digit 2, then last-digit latency.
    drive(SS_9, DIG0, 8);
    drive(SS_7, DIG1, 8);
    drive(SS_5, DIG2, 2);
    drive(8'h00, DIG2, 1);
    drive(SS_5, DIG2, 8);
    c0 = cyc;
    n0 = obs_q.size();
    drive(SS_C, DIG3, 8);
    drive(SS_BLANK, 4'hF, 20);
    check_frames("glitch");
    check("glitch_value", 32'(value), 32'hC579);
    check("glitch_err", 32'(frame_err), 32'h0);
    check("latency", 32'(obs_cyc[n0] - c0), 32'(LAT));

    // Undecodable digit 1 with its dp lit.
    drive(SS_F, DIG0, 8);
    drive(8'hFE, DIG1, 8);
    drive(SS_E, DIG2, 8);
    drive(SS_A, DIG3, 8);
    drive(SS_BLANK, 4'hF, 20);
    check_frames("baddig");
    check("baddig_value", 32'(value), 32'hAE0F);
    check("baddig_dp", 32'(dp), 32'h2);
    check("baddig_err", 32'(frame_err), 32'h2);

    // Blanking between digits plus an illegal two-digit enable.
    drive(SS_B, DIG0, 8);
    drive(SS_BLANK, 4'hF, 20);
    drive(SS_D, 4'b1100, 8);
    drive(SS_BLANK, 4'hF, 20);
    drive(SS_6, DIG1, 8);
    drive(SS_BLANK, 4'hF, 20);
    drive(SS_0, DIG2, 8);
    drive(SS_BLANK, 4'hF, 20);
    drive(SS_D, DIG3, 8);
    drive(SS_BLANK, 4'hF, 20);
    check_frames("blank");
    check("blank_value", 32'(value), 32'hD06B);
    check("blank_err", 32'(frame_err), 32'h0);

    // Reset with half a frame collected.
    drive(SS_3, DIG0, 8);
    drive(SS_7, DIG1, 8);
    drive(SS_BLANK, 4'hF, 10);
    check("mid_busy", 32'(busy), 32'h1);
    do_reset("mid");
    n1 = obs_q.size();
    drive(SS_8, DIG0, 8);
    drive(SS_8, DIG1, 8);
    drive(SS_8, DIG2, 8);
    drive(SS_8, DIG3, 8);
    drive(SS_BLANK, 4'hF, 20);
    check("mid_frames", 32'(obs_q.size() - n1), 32'h1);
    check_frames("mid");
    check("mid_value", 32'(value), 32'h8888);

    // Randomized dwells: mostly legal glyphs on single digits.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 99) < 75)
        seg_r = {ref_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
      else
        seg_r = 8'($urandom);
      if ($urandom_range(0, 99) < 70) begin
        ctl_r = 4'hF;
        ctl_r[$urandom_range(0, 3)] = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        ctl_r = 4'hF;
      end else begin
        ctl_r = 4'($urandom);
      end
      drive(seg_r, ctl_r, $urandom_range(1, 10));
    end
    drive(SS_BLANK, 4'hF, 30);
    check_frames("rand");
    check("rand_busy", 32'(busy), 32'(m_seen != 4'h0));
    check("stable_outputs", 32'(bad_change), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
